prefetch_buffer: RTL and testbench

Parametrised instruction prefetch unit for the IF stage: fetches aligned 32-bit words from program memory with up to `MAX_OUTSTANDING` requests in flight, buffers them in a `FIFO_DEPTH`-entry queue, and realigns mixed 16/32-bit (RVC) instructions into a valid/ready stream for the decoder. It supersedes the single-request fetch FSM and adds:

- pipelined multi-outstanding fetch with credit-based flow control;
- discard of stale responses after a redirect;
- a true valid/ready output handshake.

---
 rtl/prefetch_buffer.sv | 160 ++++++++++++++++
 tb/tb_prefetch_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buffer.sv
// Instruction prefetch unit: pipelined word fetch with credit-based flow control,
// a small word FIFO, and realignment of mixed 16/32-bit instructions into a
// valid/ready stream for the decoder.
module prefetch_buffer #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] boot_addr,
  input  logic        fetch_enable,
  input  logic        branch_valid,
  input  logic [31:0] branch_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_err,
  output logic        out_compressed,
  output logic        busy,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic [31:0] instr_rdata,
  input  logic        instr_err,
  input  logic        instr_valid
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     pc_q, pc_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic [OutW-1:0] discard_q, discard_d;
  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [32:0]     fifo_mem [FIFO_DEPTH];

  logic [CntW-1:0] eff_count;
  logic            credit_ok;
  logic [31:0]     branch_word;
  logic            granted;
  logic            resp;
  logic            push;
  logic            pop;
  logic            handshake;
  logic [PtrW-1:0] nptr;
  logic [32:0]     head;
  logic [15:0]     half_lo;
  logic            is32;
  logic            straddle;
  logic            have_entries;
  logic [31:0]     pc_step;

  // Request issue: a redirect flushes the FIFO, so credit is computed against empty.
  always_comb begin
    eff_count   = branch_valid ? '0 : count_q;
    credit_ok   = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                  (32'(eff_count) + 32'(outstanding_q) < FIFO_DEPTH);
    instr_req   = ~reset & fetch_enable & credit_ok;
    branch_word = {branch_addr[31:2], 2'b00};
    instr_addr  = branch_valid ? branch_word : fetch_addr_q;
    granted     = instr_req & instr_gnt;
    // A response with nothing in flight is a protocol violation and is ignored.
    resp        = instr_valid & (outstanding_q != '0);
    push        = resp & (discard_q == '0) & ~branch_valid & ~reset;
    busy        = ~reset & (outstanding_q != '0);
  end

  // Realignment of the instruction at pc from the FIFO head and the entry after it.
  always_comb begin
    nptr           = rptr_q + PtrW'(1);
    head           = fifo_mem[rptr_q];
    half_lo        = pc_q[1] ? head[31:16] : head[15:0];
    is32           = (half_lo[1:0] == 2'b11);
    straddle       = pc_q[1] & is32;
    if (is32) begin
      out_instr = {(straddle ? fifo_mem[nptr][15:0] : head[31:16]), half_lo};
    end else begin
      out_instr = {16'h0000, half_lo};
    end
    out_err        = head[32] | (straddle & fifo_mem[nptr][32]);
    out_compressed = ~is32;
    out_pc         = pc_q;
    have_entries   = straddle ? (count_q >= CntW'(2)) : (count_q != '0);
    out_valid      = have_entries & ~branch_valid & ~reset;
    handshake      = out_valid & out_ready;
    // The head word is finished once the instruction reaches its upper half.
    pop            = handshake & (pc_q[1] | is32);
    pc_step        = is32 ? 32'd4 : 32'd2;
  end

  // Next-state for addresses, counters and FIFO pointers; redirect wins over all.
  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q + OutW'(granted) - OutW'(resp);
    discard_d     = discard_q;
    rptr_d        = rptr_q;
    wptr_d        = wptr_q;
    count_d       = count_q;
    if (branch_valid) begin
      fetch_addr_d = branch_word + (granted ? 32'd4 : 32'd0);
      pc_d         = branch_addr;
      // Everything still in flight is stale; this cycle's response is dropped already.
      discard_d    = outstanding_q - OutW'(resp);
      rptr_d       = '0;
      wptr_d       = '0;
      count_d      = '0;
    end else begin
      if (granted) begin
        fetch_addr_d = fetch_addr_q + 32'd4;
      end
      if (resp && (discard_q != '0)) begin
        discard_d = discard_q - OutW'(1);
      end
      if (push) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      if (handshake) begin
        pc_d = pc_q + pc_step;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr_q  <= {boot_addr[31:2], 2'b00};
      pc_q          <= boot_addr;
      outstanding_q <= '0;
      discard_q     <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr_q] <= {instr_err, instr_rdata};
    end
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: directed scenarios plus randomized traffic, checked every
// cycle against a model that derives instructions straight from the memory image.
module tb_prefetch_buffer;

  localparam int unsigned Depth  = 4;
  localparam int unsigned MaxOut = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] boot_addr = 32'h0;
  logic        fetch_enable = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_err;
  logic        out_compressed;
  logic        busy;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt = 1'b0;
  logic [31:0] instr_rdata = 32'h0;
  logic        instr_err = 1'b0;
  logic        instr_valid = 1'b0;

  always #5 clk = ~clk;

  prefetch_buffer #(
    .FIFO_DEPTH     (Depth),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .boot_addr     (boot_addr),
    .fetch_enable  (fetch_enable),
    .branch_valid  (branch_valid),
    .branch_addr   (branch_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_err       (out_err),
    .out_compressed(out_compressed),
    .busy          (busy),
    .instr_req     (instr_req),
    .instr_addr    (instr_addr),
    .instr_gnt     (instr_gnt),
    .instr_rdata   (instr_rdata),
    .instr_err     (instr_err),
    .instr_valid   (instr_valid)
  );

  // Memory image (address bits [9:2] select the word, so all addresses alias into it).
  logic [31:0] mem_w [256];
  logic        mem_e [256];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t memq[$];
  int    cyc = 0;
  int    last_due = 0;
  int    lat = 1;

  // Reference model state.
  logic [31:0] m_fetch;
  logic [31:0] m_pc;
  bit          infl[$];   // one entry per request in flight, 1 = stale
  int          fifo_n;
  logic [31:0] hs_pc[$];
  logic [31:0] hs_instr[$];
  bit          hs_err[$];
  bit          hs_comp[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = mem_w[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic bit werr(input logic [31:0] a);
    return mem_e[a[9:2]];
  endfunction

  // Compare process: check outputs against the model, then advance the model.
  always @(negedge clk) begin : compare
    logic [31:0] e_addr, e_instr, npc;
    logic [15:0] lo;
    bit e_req, e_valid, e_busy, e_err, is32, resp, grant, pushw, popw;
    int need, eff;
    if (reset) begin
      chk("busy_rst", 32'(busy), 0);
      chk("req_rst", 32'(instr_req), 0);
      chk("valid_rst", 32'(out_valid), 0);
      m_fetch = {boot_addr[31:2], 2'b00};
      m_pc    = boot_addr;
      infl.delete();
      fifo_n  = 0;
    end else begin
      e_busy  = (infl.size() != 0);
      eff     = branch_valid ? 0 : fifo_n;
      e_req   = fetch_enable && (infl.size() < MaxOut) && (eff + infl.size() < Depth);
      e_addr  = branch_valid ? {branch_addr[31:2], 2'b00} : m_fetch;
      lo      = half(m_pc);
      is32    = (lo[1:0] == 2'b11);
      need    = (m_pc[1] && is32) ? 2 : 1;
      e_valid = !branch_valid && (fifo_n >= need);
      e_instr = is32 ? {half(m_pc + 32'd2), lo} : {16'h0, lo};
      e_err   = werr(m_pc) | (is32 & werr(m_pc + 32'd2));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("instr_req", 32'(instr_req), 32'(e_req));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      if (e_req) chk("instr_addr", instr_addr, e_addr);
      if (e_valid) begin
        chk("out_pc", out_pc, m_pc);
        chk("out_instr", out_instr, e_instr);
        chk("out_err", 32'(out_err), 32'(e_err));
        chk("out_compressed", 32'(out_compressed), 32'(!is32));
      end
      resp  = instr_valid && (infl.size() > 0);
      grant = e_req && instr_gnt;
      if (branch_valid) begin
        if (resp) void'(infl.pop_front());
        foreach (infl[k]) infl[k] = 1'b1;
        fifo_n  = 0;
        m_pc    = branch_addr;
        m_fetch = {branch_addr[31:2], 2'b00} + (grant ? 32'd4 : 32'd0);
        if (grant) infl.push_back(1'b0);
      end else begin
        pushw = 1'b0;
        popw  = 1'b0;
        if (resp) pushw = !infl.pop_front();
        if (e_valid && out_ready) begin
          hs_pc.push_back(m_pc);
          hs_instr.push_back(e_instr);
          hs_err.push_back(e_err);
          hs_comp.push_back(!is32);
          npc  = m_pc + (is32 ? 32'd4 : 32'd2);
          popw = (npc[31:2] != m_pc[31:2]);
          m_pc = npc;
        end
        fifo_n = fifo_n + int'(pushw) - int'(popw);
        if (grant) begin
          m_fetch = m_fetch + 32'd4;
          infl.push_back(1'b0);
        end
      end
    end
  end

  // One clock: capture a grant for the memory, then present any due response.
  task automatic tick();
    int    due;
    mreq_t r;
    @(negedge clk);
    #1;
    if (!reset && instr_req && instr_gnt) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: instr_addr, due: due});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      r           = memq.pop_front();
      instr_valid = 1'b1;
      instr_rdata = mem_w[r.addr[9:2]];
      instr_err   = mem_e[r.addr[9:2]];
    end else begin
      instr_valid = 1'b0;
      instr_rdata = $urandom;
      instr_err   = 1'b0;
    end
  endtask

  task automatic clear_hs();
    hs_pc.delete();
    hs_instr.delete();
    hs_err.delete();
    hs_comp.delete();
  endtask

  task automatic do_reset(input logic [31:0] boot);
    reset        = 1'b1;
    boot_addr    = boot;
    branch_valid = 1'b0;
    fetch_enable = 1'b0;
    tick();
    for (int n = 0; n < 50 && memq.size() > 0; n++) tick();
    reset = 1'b0;
    clear_hs();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem_w[i] = 32'h0000_0013;
      mem_e[i] = 1'b0;
    end
  endtask

  task automatic pin(input string nm, input int idx, input logic [31:0] pc,
                     input logic [31:0] ins, input bit err);
    if (hs_pc.size() > idx) begin
      chk({nm, "_pc"}, hs_pc[idx], pc);
      chk({nm, "_instr"}, hs_instr[idx], ins);
      chk({nm, "_err"}, 32'(hs_err[idx]), 32'(err));
    end
  endtask

  initial begin
    int bp;
    bit draining;
    clear_mem();

    // Boot, aligned 32-bit words, 1-cycle memory.
    lat = 1;
    do_reset(32'h80);
    fetch_enable = 1'b1;
    instr_gnt    = 1'b1;
    out_ready    = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("boot_count", 32'(hs_pc.size() >= 4), 1);
    for (int i = 0; i < 4; i++) pin("boot", i, 32'h80 + 32'(4 * i), 32'h13, 1'b0);
    if (hs_comp.size() > 0) chk("boot_comp", 32'(hs_comp[0]), 0);

    // Mixed compressed/32-bit with an unaligned straddle.
    clear_mem();
    mem_w[0] = 32'h00B3_0001;
    mem_w[1] = 32'h0011_0513;
    do_reset(32'h0);
    fetch_enable = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("rvc_count", 32'(hs_pc.size() >= 4), 1);
    pin("rvc0", 0, 32'h0, 32'h0000_0001, 1'b0);
    pin("rvc1", 1, 32'h2, 32'h0513_00B3, 1'b0);
    pin("rvc2", 2, 32'h6, 32'h0000_0011, 1'b0);
    pin("rvc3", 3, 32'h8, 32'h0000_0013, 1'b0);
    if (hs_comp.size() > 1) chk("rvc_comp", 32'(hs_comp[1]), 0);

    // Bus error on the word at 0x8, including a straddle from 0x6.
    clear_mem();
    mem_w[1] = 32'hFFFF_0001;
    mem_w[2] = 32'h0001_0013;
    mem_e[2] = 1'b1;
    do_reset(32'h0);
    fetch_enable = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("err_count", 32'(hs_pc.size() >= 5), 1);
    pin("err0", 0, 32'h0, 32'h0000_0013, 1'b0);
    pin("err1", 1, 32'h4, 32'h0000_0001, 1'b0);
    pin("err2", 2, 32'h6, 32'h0013_FFFF, 1'b1);
    pin("err3", 3, 32'hA, 32'h0000_0001, 1'b1);
    pin("err4", 4, 32'hC, 32'h0000_0013, 1'b0);

    // Redirect to 0x102 with two requests in flight and 3-cycle latency.
    clear_mem();
    mem_w[64] = 32'h4505_1234;
    lat = 3;
    do_reset(32'h0);
    fetch_enable = 1'b1;
    tick();
    tick();
    clear_hs();
    branch_valid = 1'b1;
    branch_addr  = 32'h102;
    tick();
    branch_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("br_count", 32'(hs_pc.size() >= 2), 1);
    pin("br0", 0, 32'h102, 32'h0000_4505, 1'b0);
    pin("br1", 1, 32'h104, 32'h0000_0013, 1'b0);

    // Reset with two requests outstanding; late responses must be ignored.
    lat = 4;
    do_reset(32'h40);
    fetch_enable = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    fetch_enable = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    for (int n = 0; n < 20 && memq.size() > 0; n++) tick();
    chk("rst_drained", 32'(memq.size()), 0);
    clear_hs();
    fetch_enable = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("rst_count", 32'(hs_pc.size() >= 1), 1);
    pin("rst0", 0, 32'h40, 32'h0000_0013, 1'b0);

    // Randomized traffic: random image, errors, grants, latency, stalls, redirects, resets.
    for (int i = 0; i < 256; i++) begin
      mem_w[i] = $urandom;
      mem_e[i] = ($urandom % 16 == 0);
    end
    do_reset($urandom & 32'h3FE);
    bp       = 0;
    draining = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      fetch_enable = draining ? 1'b0 : ($urandom % 8 != 0);
      instr_gnt    = ($urandom % 4 != 0);
      lat          = 1 + int'($urandom % 4);
      if (bp > 0) begin
        out_ready = 1'b0;
        bp--;
      end else begin
        out_ready = ($urandom % 4 != 0);
        if ($urandom % 100 == 0) bp = 10;
      end
      branch_valid = ($urandom % 32 == 0);
      branch_addr  = $urandom & 32'hFFFF_FFFE;
      if ($urandom % 300 == 0) begin
        reset        = 1'b1;
        branch_valid = 1'b0;
        boot_addr    = $urandom & 32'h3FE;
        draining     = 1'b1;
      end else begin
        reset = 1'b0;
      end
      tick();
      if (draining && memq.size() == 0) draining = 1'b0;
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
